// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine that owns the HI/LO register pair.
// Retires BITS_PER_CYCLE result bits per RUN cycle and applies signs and accumulation in FIN.
module muldiv_hilo_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  logic [WIDTH+BITS_PER_CYCLE-1:0] mul_sum;
  logic [DW-1:0]                   mul_next, div_next;
  logic [WIDTH-1:0]                rem, quo;
  logic [WIDTH:0]                  rem_t;

  // NOTE: combinational blocks use blocking '=' so each loop iteration sees the previous one;
  // state registers below use non-blocking '<=' only.
  always_comb begin
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, acc_q[DW-1:WIDTH]};
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (acc_q[j]) mul_sum = mul_sum + ({{BITS_PER_CYCLE{1'b0}}, b_q} << j);
    end
    mul_next = DW'({mul_sum, acc_q[WIDTH-1:0]} >> BITS_PER_CYCLE);

    rem = acc_q[DW-1:WIDTH];
    quo = acc_q[WIDTH-1:0];
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      rem_t = {rem, quo[WIDTH-1]};
      quo   = quo << 1;
      if (rem_t >= {1'b0, b_q}) begin
        rem_t  = rem_t - {1'b0, b_q};
        quo[0] = 1'b1;
      end
      rem = rem_t[WIDTH-1:0];
    end
    div_next = {rem, quo};
  end

  logic             start_signed;
  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [DW-1:0]    prod_fix;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    start_signed = (op_e'(Op) == OP_MULT) || (op_e'(Op) == OP_DIV) ||
                   (op_e'(Op) == OP_MADD) || (op_e'(Op) == OP_MSUB);
    a_abs = (start_signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    b_abs = (start_signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With a zero divisor the remainder equals |A|; restoring the dividend sign yields A itself.
    rem_fix  = neg_rem_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          unique case (op_e'(Op))
            OP_MTHI: begin hi_d = OperandA; done_d = 1'b1; end
            OP_MTLO: begin lo_d = OperandA; done_d = 1'b1; end
            default: begin
              op_d      = op_e'(Op);
              b_d       = b_abs;
              acc_d     = {{WIDTH{1'b0}}, a_abs};
              neg_res_d = start_signed && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
              neg_rem_d = start_signed && OperandA[WIDTH-1];
              bzero_d   = (OperandB == '0);
              cnt_d     = '0;
              state_d   = S_RUN;
            end
          endcase
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (op_q == OP_DIV || op_q == OP_DIVU) ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!Flush) begin
          done_d = 1'b1;
          unique case (op_q)
            OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
            OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
            OP_DIV, OP_DIVU: begin
              lo_d  = bzero_q ? '1 : quo_fix;
              hi_d  = rem_fix;
              dbz_d = bzero_q;
            end
            default: {hi_d, lo_d} = prod_fix;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed plus random bench for muldiv_hilo_unit; expected results come from a 64-bit
// arithmetic model and are queued at launch, then popped when Done appears.
module tb_muldiv_hilo_unit;

  localparam int N = 32;

  logic        clk, reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz, busy4, done4, dbz4;
  logic [31:0] hi, lo, hi4, lo4;

  muldiv_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op), .OperandA(a), .OperandB(b),
    .Flush(flush), .Busy(busy), .Done(done), .DivByZero(dbz), .HI(hi), .LO(lo));

  muldiv_hilo_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .Clk(clk), .Reset(reset), .Start(start), .Op(op), .OperandA(a), .OperandB(b),
    .Flush(flush), .Busy(busy4), .Done(done4), .DivByZero(dbz4), .HI(hi4), .LO(lo4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int          edge_no = 0, launch_edge = 0, busy_cnt = 0;
  logic [31:0] hm = '0, lm = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    if (busy) busy_cnt++;
  endtask

  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] x, y,
                                        input logic [63:0] hl);
    longint      p;
    int          sx, sy;
    logic [64:0] r;
    sx = x;
    sy = y;
    p  = longint'(sx) * longint'(sy);
    r  = {1'b0, hl};
    case (o)
      3'd0: r = {1'b0, 64'(p)};
      3'd1: r = {1'b0, 64'(x) * 64'(y)};
      3'd2: begin
        if (y == 0) r = {1'b1, x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {1'b0, 32'h0, 32'h8000_0000};
        else r = {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) r = {1'b1, x, 32'hFFFF_FFFF};
        else r = {1'b0, x % y, x / y};
      end
      3'd4: r = {1'b0, hl + 64'(p)};
      3'd5: r = {1'b0, hl - 64'(p)};
      3'd6: r = {1'b0, x, hl[31:0]};
      default: r = {1'b0, hl[63:32], x};
    endcase
    return r;
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] x, y, input bit expect_it);
    logic [64:0] r;
    exp_t        e;
    if (expect_it) begin
      r     = model(o, x, y, {hm, lm});
      e.dbz = r[64];
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.lat = (o >= 3'd6) ? 0 : N + 1;
      hm    = e.hi;
      lm    = e.lo;
      sb.push_back(e);
    end
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    busy_cnt = 0;
    tick();
    launch_edge = edge_no;
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (!done && (edge_no - launch_edge) < 200) tick();
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(edge_no - launch_edge), 64'(e.lat));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
      check({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
    end
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_dbz_pulse"}, 64'(dbz), 64'd0);
  endtask

  initial begin
    logic        saw;
    logic [64:0] r4;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);

    launch(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);         wait_done("mult_neg");
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("multu_max");
    launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done("div_neg");
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("div_ovf");
    launch(3'd3, 32'd7, 32'd0, 1'b1);                 wait_done("divu_zero");
    launch(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);         wait_done("div_zero_neg");

    // Back-to-back moves: Busy must never rise.
    start = 1'b1; op = 3'd6; a = 32'h0;
    tick();
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd1);
    check("mthi_hi", 64'(hi), 64'd0);
    op = 3'd7; a = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    hm = 32'h0; lm = 32'hFFFF_FFFF;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_lo", 64'(lo), 64'(lm));
    tick();
    launch(3'd4, 32'd1, 32'd1, 1'b1); wait_done("madd_carry");
    launch(3'd5, 32'd1, 32'd1, 1'b1); wait_done("msub_borrow");
    launch(3'd6, 32'h1234_5678, 32'd0, 1'b1); wait_done("mthi_single");

    // Flush mid-run: no Done, HI/LO untouched.
    launch(3'd0, 32'd123, 32'd456, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw = 1'b1;
    end
    check("flush_no_done", 64'(saw), 64'd0);
    check("flush_hilo", {hi, lo}, {hm, lm});

    // A Start while Busy is ignored; only the first op's result appears.
    launch(3'd0, 32'hFFFF_0001, 32'h0000_7FFF, 1'b1);
    repeat (4) tick();
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    wait_done("start_ignored");

    // Synchronous reset in the middle of a DIVU.
    launch(3'd3, 32'd1000, 32'd7, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hm = '0; lm = '0;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_flags", {61'd0, busy, done, dbz}, 64'd0);

    // Flush beats Start in IDLE, even for a move.
    start = 1'b1; flush = 1'b1; op = 3'd7; a = 32'd5;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_lo", 64'(lo), 64'(lm));
    check("flush_start_busy", 64'(busy), 64'd0);
    tick();
    check("flush_start_done", 64'(done), 64'd0);

    // Four bits per cycle: Done follows edge 9 on the wide-step instance.
    r4 = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    while (!done4 && (edge_no - launch_edge) < 200) tick();
    check("b4_latency", 64'(edge_no - launch_edge), 64'd9);
    check("b4_hilo", {hi4, lo4}, r4[63:0]);
    check("b4_const", {hi4, lo4}, 64'h0B00_EA4E_242D_2080);
    wait_done("b1_same_op");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 300));
      launch(3'($urandom_range(0, 5)), ra, rb, 1'b1);
      wait_done("random_op");
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
